// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and defaults for the UART blocks
package uart_pkg;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP,
      RX_BRK_WAIT
   } uart_rx_state_t;

   localparam int UART_OVERSAMPLE_DEFAULT = 16;
   localparam int UART_DATA_BITS_DEFAULT  = 8;

endpackage

// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - received-byte handshake between uart_rx and its consumer
interface uart_rx_if;
   import uart_pkg::*;

   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic       frame_err;
   logic       overrun_err;

   modport master (
      output rx_data, rx_valid, frame_err, overrun_err,
      input  rx_ready
   );

   modport slave (
      input  rx_data, rx_valid, frame_err, overrun_err,
      output rx_ready
   );

endinterface

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - free-running oversample tick generator, a divisor of 0 acts as 1
module uart_baud_gen
   import uart_pkg::*;
#(
   parameter int BAUD_DIV_WIDTH = 16
) (
   input  logic                      clk,
   input  logic                      rstn,
   input  logic [BAUD_DIV_WIDTH-1:0] i_baud_div,
   output logic                      o_tick
);

   logic [BAUD_DIV_WIDTH-1:0] r_cnt;
   logic [BAUD_DIV_WIDTH-1:0] w_last;

   assign w_last = (i_baud_div == '0) ? '0 : i_baud_div - BAUD_DIV_WIDTH'(1);
   // >= so a divisor lowered on the fly wraps at once instead of running to overflow
   assign o_tick = (r_cnt >= w_last);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_cnt <= '0;
      end else if (o_tick) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + BAUD_DIV_WIDTH'(1);
      end
   end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver: rxd synchroniser, 16x oversampling FSM, single-entry byte holder
module uart_rx
   import uart_pkg::*;
#(
   parameter int DATA_BITS      = UART_DATA_BITS_DEFAULT,
   parameter int OVERSAMPLE     = UART_OVERSAMPLE_DEFAULT,
   parameter int BAUD_DIV_WIDTH = 16
) (
   input  logic                      clk,
   input  logic                      rstn,
   input  logic [BAUD_DIV_WIDTH-1:0] i_baud_div,
   input  logic                      i_rx_enable,
   input  logic                      i_rxd,
   uart_rx_if.master                 rx
);

   localparam int             TW       = $clog2(OVERSAMPLE);
   localparam logic [TW-1:0]  MID_TICK = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0]  BIT_TICK = TW'(OVERSAMPLE - 1);
   localparam logic [3:0]     LAST_BIT = 4'(DATA_BITS - 1);

   logic                 r_rxd_meta;
   logic                 r_rxd_s;
   logic                 w_tick;
   uart_rx_state_t       r_state;
   logic [TW-1:0]        r_tick_cnt;
   logic [3:0]           r_bit_cnt;
   logic [DATA_BITS-1:0] r_shift;
   logic                 r_deliver;
   logic                 r_stop_bit;
   logic [7:0]           r_data;
   logic                 r_valid;
   logic                 r_ferr;
   logic                 r_ovr;
   logic                 w_pop;

   // Synchroniser resets to the idle level so reset release cannot look like a start bit
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_rxd_meta <= 1'b1;
         r_rxd_s    <= 1'b1;
      end else begin
         r_rxd_meta <= i_rxd;
         r_rxd_s    <= r_rxd_meta;
      end
   end

   uart_baud_gen #(.BAUD_DIV_WIDTH(BAUD_DIV_WIDTH)) u_baud_gen (
      .clk        (clk),
      .rstn       (rstn),
      .i_baud_div (i_baud_div),
      .o_tick     (w_tick)
   );

   // Once the start bit is centred every later sample is a whole bit period further on
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state    <= RX_IDLE;
         r_tick_cnt <= '0;
         r_bit_cnt  <= '0;
         r_shift    <= '0;
         r_deliver  <= 1'b0;
         r_stop_bit <= 1'b0;
      end else begin
         r_deliver <= 1'b0;
         if (!i_rx_enable) begin
            r_state <= RX_IDLE;
         end else begin
            case (r_state)
               RX_IDLE: begin
                  if (!r_rxd_s) begin
                     r_state    <= RX_START;
                     r_tick_cnt <= '0;
                     r_bit_cnt  <= '0;
                  end
               end
               RX_START: begin
                  if (w_tick) begin
                     if (r_tick_cnt == MID_TICK) begin
                        r_tick_cnt <= '0;
                        r_state    <= r_rxd_s ? RX_IDLE : RX_DATA;
                     end else begin
                        r_tick_cnt <= r_tick_cnt + TW'(1);
                     end
                  end
               end
               RX_DATA: begin
                  if (w_tick) begin
                     if (r_tick_cnt == BIT_TICK) begin
                        r_tick_cnt <= '0;
                        r_shift    <= {r_rxd_s, r_shift[DATA_BITS-1:1]};
                        r_bit_cnt  <= r_bit_cnt + 4'd1;
                        if (r_bit_cnt == LAST_BIT) begin
                           r_state <= RX_STOP;
                        end
                     end else begin
                        r_tick_cnt <= r_tick_cnt + TW'(1);
                     end
                  end
               end
               RX_STOP: begin
                  if (w_tick) begin
                     if (r_tick_cnt == BIT_TICK) begin
                        r_tick_cnt <= '0;
                        r_deliver  <= 1'b1;
                        r_stop_bit <= r_rxd_s;
                        r_state    <= r_rxd_s ? RX_IDLE : RX_BRK_WAIT;
                     end else begin
                        r_tick_cnt <= r_tick_cnt + TW'(1);
                     end
                  end
               end
               RX_BRK_WAIT: begin
                  if (r_rxd_s) begin
                     r_state <= RX_IDLE;
                  end
               end
               default: r_state <= RX_IDLE;
            endcase
         end
      end
   end

   assign w_pop = r_valid && rx.rx_ready;

   // A pop in the delivery cycle frees the slot, so the new byte is taken without overrun
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_data  <= '0;
         r_valid <= 1'b0;
         r_ferr  <= 1'b0;
         r_ovr   <= 1'b0;
      end else begin
         r_ovr <= 1'b0;
         if (r_deliver) begin
            if (!r_valid || w_pop) begin
               r_data  <= 8'(r_shift);
               r_ferr  <= ~r_stop_bit;
               r_valid <= 1'b1;
            end else begin
               r_ovr <= 1'b1;
            end
         end else if (w_pop) begin
            r_valid <= 1'b0;
         end
      end
   end

   assign rx.rx_data     = r_data;
   assign rx.rx_valid    = r_valid;
   assign rx.frame_err   = r_ferr;
   assign rx.overrun_err = r_ovr;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx
module tb_uart_rx;
   import uart_pkg::*;

   logic        clk = 1'b0;
   logic        rstn;
   logic [15:0] baud_div;
   logic        rx_enable;
   logic        rxd;

   uart_rx_if rif();

   uart_rx #(.DATA_BITS(8), .OVERSAMPLE(16), .BAUD_DIV_WIDTH(16)) dut (
      .clk         (clk),
      .rstn        (rstn),
      .i_baud_div  (baud_div),
      .i_rx_enable (rx_enable),
      .i_rxd       (rxd),
      .rx          (rif)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] data;
      logic       ferr;
   } rx_item_t;

   typedef struct {
      logic [7:0] data;
      logic       stop;
      int         div;
      logic [7:0] exp_data;
      logic       exp_ferr;
   } vec_t;

   int       total = 0;
   int       bad = 0;
   int       cyc = 0;
   int       vcyc = 0;
   int       ovr_cnt = 0;
   int       ovr_cyc = 0;
   int       drop_cnt = 0;
   logic     watch = 1'b0;
   rx_item_t got_q[$];
   rx_item_t exp_q[$];
   vec_t     vecs[6];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rif.rx_valid) vcyc++;
      if (rif.rx_valid && rif.rx_ready) got_q.push_back({rif.rx_data, rif.frame_err});
      if (rif.overrun_err) begin
         ovr_cnt++;
         ovr_cyc = cyc;
      end
      if (watch && !rif.rx_valid) drop_cnt++;
   end

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic int bclk(input int d);
      return 16 * ((d == 0) ? 1 : d);
   endfunction

   // Leaves rxd at the stop level; caller decides how long the line stays there
   task automatic send_frame(input logic [7:0] d, input logic stop, input int bc, output int start_cyc);
      rxd = 1'b0;
      start_cyc = cyc;
      tick(bc);
      for (int i = 0; i < 8; i++) begin
         rxd = d[i];
         tick(bc);
      end
      rxd = stop;
      tick(bc);
   endtask

   task automatic frame(input logic [7:0] d, input logic stop);
      int s;
      send_frame(d, stop, bclk(int'(baud_div)), s);
      rxd = 1'b1;
      tick(2 * bclk(int'(baud_div)));
   endtask

   task automatic check_queue(input string nm);
      chk({nm, " count"}, got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         chk({nm, " data"}, got_q[i].data, exp_q[i].data);
         chk({nm, " ferr"}, got_q[i].ferr, exp_q[i].ferr);
      end
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic check_outputs_zero(input string nm);
      chk({nm, " rx_data"}, rif.rx_data, 0);
      chk({nm, " rx_valid"}, rif.rx_valid, 0);
      chk({nm, " frame_err"}, rif.frame_err, 0);
      chk({nm, " overrun_err"}, rif.overrun_err, 0);
   endtask

   task automatic reset_mid_frame(input int div);
      baud_div = 16'(div);
      tick(8);
      rxd = 1'b0;
      tick(bclk(div));
      for (int i = 0; i < 4; i++) begin
         rxd = 1'(8'hF0 >> i);
         tick(bclk(div));
      end
      rxd = 1'b1;
      tick(bclk(div) / 2);
      rstn = 1'b0;
      #1;
      check_outputs_zero("mid-frame reset");
      tick(3);
      check_outputs_zero("held reset");
      rstn = 1'b1;
      got_q.delete();
      tick(2 * bclk(div));
      frame(8'h5A, 1'b1);
      exp_q.push_back({8'h5A, 1'b0});
      check_queue("after reset");
   endtask

   initial begin
      int f1, f2, off, ovr_before, n, d;
      logic [7:0] rb;
      logic       rs;

      vecs[0] = '{8'hA5, 1'b1, 4, 8'hA5, 1'b0};
      vecs[1] = '{8'h00, 1'b1, 4, 8'h00, 1'b0};
      vecs[2] = '{8'hFF, 1'b1, 2, 8'hFF, 1'b0};
      vecs[3] = '{8'h3C, 1'b0, 4, 8'h3C, 1'b1};
      vecs[4] = '{8'h81, 1'b1, 0, 8'h81, 1'b0};
      vecs[5] = '{8'h7E, 1'b0, 1, 8'h7E, 1'b1};

      rstn = 1'b0;
      baud_div = 16'd4;
      rx_enable = 1'b1;
      rxd = 1'b1;
      rif.rx_ready = 1'b1;
      tick(4);
      check_outputs_zero("reset");
      rstn = 1'b1;
      tick(20);

      for (int i = 0; i < 6; i++) begin
         baud_div = 16'(vecs[i].div);
         tick(8);
         vcyc = 0;
         ovr_cnt = 0;
         frame(vecs[i].data, vecs[i].stop);
         chk("vec count", got_q.size(), 1);
         if (got_q.size() > 0) begin
            chk("vec data", got_q[0].data, vecs[i].exp_data);
            chk("vec ferr", got_q[0].ferr, vecs[i].exp_ferr);
         end
         chk("vec valid cycles", vcyc, 1);
         chk("vec overrun", ovr_cnt, 0);
         got_q.delete();
      end

      baud_div = 16'd4;
      tick(8);
      rx_enable = 1'b0;
      frame(8'h99, 1'b1);
      chk("disabled count", got_q.size(), 0);
      rx_enable = 1'b1;
      tick(8);

      // short low glitch must be rejected as a false start
      vcyc = 0;
      rxd = 1'b0;
      tick(20);
      rxd = 1'b1;
      tick(200);
      chk("glitch count", got_q.size(), 0);
      chk("glitch valid", vcyc, 0);
      frame(8'h3C, 1'b1);
      exp_q.push_back({8'h3C, 1'b0});
      check_queue("after glitch");

      // framing error followed by a held break
      send_frame(8'h3C, 1'b0, 64, f1);
      tick(200);
      chk("break count", got_q.size(), 1);
      rxd = 1'b1;
      tick(128);
      frame(8'h81, 1'b1);
      exp_q.push_back({8'h3C, 1'b1});
      exp_q.push_back({8'h81, 1'b0});
      check_queue("break");

      // overrun with consumer stalled
      rif.rx_ready = 1'b0;
      ovr_cnt = 0;
      frame(8'h11, 1'b1);
      frame(8'h22, 1'b1);
      chk("stall rx_data", rif.rx_data, 8'h11);
      chk("stall rx_valid", rif.rx_valid, 1);
      chk("stall overrun pulses", ovr_cnt, 1);
      rif.rx_ready = 1'b1;
      tick(1);
      rif.rx_ready = 1'b0;
      tick(2);
      chk("after pop rx_valid", rif.rx_valid, 0);
      chk("after pop rx_data", rif.rx_data, 8'h11);
      exp_q.push_back({8'h11, 1'b0});
      check_queue("stall pop");

      // pop coinciding with delivery: measure delivery offset via an overrun, then reuse it
      frame(8'h55, 1'b1);
      ovr_before = ovr_cnt;
      send_frame(8'h77, 1'b1, 64, f1);
      tick(128);
      chk("probe overrun", ovr_cnt, ovr_before + 1);
      off = ovr_cyc - f1;
      while ((cyc % 4) != (f1 % 4)) tick(1);
      ovr_before = ovr_cnt;
      f2 = cyc;
      watch = 1'b1;
      fork
         send_frame(8'h66, 1'b1, 64, n);
         begin
            while (cyc < f2 + off - 1) tick(1);
            rif.rx_ready = 1'b1;
            tick(1);
            rif.rx_ready = 1'b0;
         end
      join
      tick(128);
      watch = 1'b0;
      chk("same-cycle rx_data", rif.rx_data, 8'h66);
      chk("same-cycle rx_valid", rif.rx_valid, 1);
      chk("same-cycle overrun", ovr_cnt, ovr_before);
      chk("same-cycle valid drop", drop_cnt, 0);
      exp_q.push_back({8'h55, 1'b0});
      check_queue("same-cycle pop");
      rif.rx_ready = 1'b1;
      tick(2);
      got_q.delete();

      reset_mid_frame(4);
      reset_mid_frame(0);

      // randomized frames against the reference rule: byte as sent, frame_err = not stop
      vcyc = 0;
      ovr_cnt = 0;
      n = 16;
      for (int i = 0; i < n; i++) begin
         d = int'($urandom_range(0, 5));
         rb = 8'($urandom);
         rs = ($urandom_range(0, 3) != 0);
         baud_div = 16'(d);
         tick(8);
         frame(rb, rs);
         exp_q.push_back({rb, ~rs});
      end
      chk("random valid cycles", vcyc, n);
      chk("random overrun", ovr_cnt, 0);
      check_queue("random");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
